// File: rtl/drive_arbiter_pkg.sv
// Shared encodings for drive_arbiter: motion modes, FSM states, tracker patterns
// and the clock-to-millisecond helper.
package drive_arbiter_pkg;

  typedef enum logic [1:0] {
    MODE_FWD   = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_STOP  = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FOLLOW  = 3'd1,
    ST_BLOCKED = 3'd2,
    ST_SEARCH  = 3'd3,
    ST_LOST    = 3'd4
  } state_t;

  // Tracker patterns as {left, mid, right}, 1 = line under sensor.
  localparam logic [2:0] TRK_NONE      = 3'b000;
  localparam logic [2:0] TRK_RIGHT     = 3'b001;
  localparam logic [2:0] TRK_MID       = 3'b010;
  localparam logic [2:0] TRK_MID_RIGHT = 3'b011;
  localparam logic [2:0] TRK_LEFT      = 3'b100;
  localparam logic [2:0] TRK_SPLIT     = 3'b101;
  localparam logic [2:0] TRK_LEFT_MID  = 3'b110;
  localparam logic [2:0] TRK_ALL       = 3'b111;

  typedef struct packed {
    logic       valid;
    logic [1:0] mode;
  } track_dec_t;

  function automatic int cycles_per_ms(input int clk_hz);
    return (clk_hz < 1000) ? 1 : clk_hz / 1000;
  endfunction

  // valid=0 for the lost (000) and split (101) patterns; the caller decides what those mean.
  function automatic track_dec_t decode_track(input logic [2:0] pat);
    track_dec_t d;
    d.valid = 1'b1;
    d.mode  = MODE_FWD;
    case (pat)
      TRK_MID, TRK_ALL:         d.mode = MODE_FWD;
      TRK_LEFT, TRK_LEFT_MID:   d.mode = MODE_LEFT;
      TRK_RIGHT, TRK_MID_RIGHT: d.mode = MODE_RIGHT;
      default:                  d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/drive_arbiter_ms_tick.sv
// Free-running 1 ms strobe: one-cycle pulse every CYCLES clocks, shared by the
// search timer and the soft-start ramp.
module drive_arbiter_ms_tick #(
  parameter int CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/drive_arbiter.sv
// drive_arbiter: fuses line tracker, ranger and start request into a registered motion command.
// Define ARB_SOFT_START_EN to ramp duty from DUTY_MAX/4 instead of jumping to DUTY_MAX.
module drive_arbiter
  import drive_arbiter_pkg::*;
#(
  parameter int CLK_HZ        = 100000000,
  parameter int STOP_CM       = 15,
  parameter int GO_CM         = 20,
  parameter int CLEAR_SAMPLES = 3,
  parameter int SEARCH_MS     = 500,
  parameter int DUTY_MAX      = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_track,
  input  logic       mid_track,
  input  logic       right_track,
  input  logic [9:0] distance_cm,
  input  logic       dist_valid,
  input  logic       start_move,
  output logic [1:0] mode,
  output logic [1:0] pre_mode,
  output logic       en_left,
  output logic       en_right,
  output logic [9:0] duty,
  output logic [2:0] state_dbg
);

  localparam int CYCLES_MS = cycles_per_ms(CLK_HZ);
  localparam int CLR_W     = $clog2(CLEAR_SAMPLES + 1);
  localparam int MS_W      = $clog2(SEARCH_MS + 1);

  localparam logic [9:0]       STOP_LIM  = 10'(STOP_CM);
  localparam logic [9:0]       GO_LIM    = 10'(GO_CM);
  localparam logic [9:0]       DUTY_FULL = 10'(DUTY_MAX);
  localparam logic [CLR_W-1:0] CLR_DONE  = CLR_W'(CLEAR_SAMPLES);
  localparam logic [MS_W-1:0]  MS_LAST   = MS_W'(SEARCH_MS - 1);

  logic [2:0]       w_pins;
  logic [2:0]       w_sync;
  logic             w_tick;
  track_dec_t       w_dec;
  logic             w_line_lost;
  logic             w_obstacle;
  logic             w_clear_done;
  logic             w_search_timeout;
  logic [1:0]       w_follow_mode;
  logic [1:0]       w_search_mode;
  logic [CLR_W-1:0] w_clr_next;
  logic [9:0]       w_duty_entry;
  logic [9:0]       w_duty_run;

  state_t           r_state;
  logic [1:0]       r_mode;
  logic [1:0]       r_pre_mode;
  logic             r_en_left;
  logic             r_en_right;
  logic [9:0]       r_duty;
  logic [CLR_W-1:0] r_clr_cnt;
  logic [MS_W-1:0]  r_ms_cnt;

  assign w_pins = {left_track, mid_track, right_track};

  // Two-flop synchronizer per tracker pin.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic r_s1;
      logic r_s2;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_s1 <= 1'b0;
          r_s2 <= 1'b0;
        end else begin
          r_s1 <= w_pins[gi];
          r_s2 <= r_s1;
        end
      end
      assign w_sync[gi] = r_s2;
    end
  endgenerate

  drive_arbiter_ms_tick #(
    .CYCLES(CYCLES_MS)
  ) u_ms_tick (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  assign w_dec         = decode_track(w_sync);
  assign w_line_lost   = (w_sync == TRK_NONE);
  assign w_obstacle    = dist_valid && (distance_cm < STOP_LIM);
  // Split pattern (and an unusable pattern on entry) keeps whatever mode is already out.
  assign w_follow_mode = w_dec.valid ? w_dec.mode : r_mode;
  assign w_search_mode = ((r_pre_mode == MODE_LEFT) || (r_pre_mode == MODE_RIGHT)) ? r_pre_mode
                                                                                     : MODE_LEFT;

  always_comb begin
    w_clr_next = r_clr_cnt;
    if (dist_valid) begin
      if (distance_cm < GO_LIM) begin
        w_clr_next = '0;
      end else if (r_clr_cnt != CLR_DONE) begin
        w_clr_next = r_clr_cnt + CLR_W'(1);
      end
    end
  end

  assign w_clear_done     = (w_clr_next == CLR_DONE);
  assign w_search_timeout = w_tick && (r_ms_cnt == MS_LAST);

`ifdef ARB_SOFT_START_EN
  localparam logic [10:0] DUTY_STEP = 11'((DUTY_MAX + 1) / 16);
  logic [10:0] w_duty_sum;
  assign w_duty_sum   = {1'b0, r_duty} + DUTY_STEP;
  assign w_duty_entry = 10'(DUTY_MAX / 4);
  assign w_duty_run   = !w_tick ? r_duty :
                        (w_duty_sum > {1'b0, DUTY_FULL}) ? DUTY_FULL : w_duty_sum[9:0];
`else
  assign w_duty_entry = DUTY_FULL;
  assign w_duty_run   = DUTY_FULL;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_STOP;
      r_pre_mode <= MODE_FWD;
      r_en_left  <= 1'b0;
      r_en_right <= 1'b0;
      r_duty     <= '0;
      r_clr_cnt  <= '0;
      r_ms_cnt   <= '0;
    end else begin
      // Stopped outputs and cleared counters unless the branch below keeps them.
      r_mode     <= MODE_STOP;
      r_en_left  <= 1'b0;
      r_en_right <= 1'b0;
      r_duty     <= '0;
      r_clr_cnt  <= '0;
      r_ms_cnt   <= '0;
      if (!start_move) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_FOLLOW;
            r_mode     <= w_follow_mode;
            r_en_left  <= 1'b1;
            r_en_right <= 1'b1;
            r_duty     <= w_duty_entry;
            if (w_follow_mode != MODE_STOP) r_pre_mode <= w_follow_mode;
          end
          ST_FOLLOW: begin
            if (w_obstacle) begin
              r_state <= ST_BLOCKED;
            end else if (w_line_lost) begin
              r_state    <= ST_SEARCH;
              r_mode     <= w_search_mode;
              r_pre_mode <= w_search_mode;
              r_en_left  <= 1'b1;
              r_en_right <= 1'b1;
              r_duty     <= w_duty_run;
            end else begin
              r_mode     <= w_follow_mode;
              r_en_left  <= 1'b1;
              r_en_right <= 1'b1;
              r_duty     <= w_duty_run;
              if (w_follow_mode != MODE_STOP) r_pre_mode <= w_follow_mode;
            end
          end
          ST_BLOCKED: begin
            if (w_clear_done) begin
              r_state    <= ST_FOLLOW;
              r_mode     <= w_follow_mode;
              r_en_left  <= 1'b1;
              r_en_right <= 1'b1;
              r_duty     <= w_duty_entry;
              if (w_follow_mode != MODE_STOP) r_pre_mode <= w_follow_mode;
            end else begin
              r_clr_cnt <= w_clr_next;
            end
          end
          ST_SEARCH: begin
            if (w_obstacle) begin
              r_state <= ST_BLOCKED;
            end else if (!w_line_lost) begin
              r_state    <= ST_FOLLOW;
              r_mode     <= w_follow_mode;
              r_en_left  <= 1'b1;
              r_en_right <= 1'b1;
              r_duty     <= w_duty_run;
              if (w_follow_mode != MODE_STOP) r_pre_mode <= w_follow_mode;
            end else if (w_search_timeout) begin
              r_state <= ST_LOST;
            end else begin
              r_mode     <= w_search_mode;
              r_pre_mode <= w_search_mode;
              r_en_left  <= 1'b1;
              r_en_right <= 1'b1;
              r_duty     <= w_duty_run;
              r_ms_cnt   <= w_tick ? r_ms_cnt + MS_W'(1) : r_ms_cnt;
            end
          end
          ST_LOST: begin
            r_state <= ST_LOST;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mode      = r_mode;
  assign pre_mode  = r_pre_mode;
  assign en_left   = r_en_left;
  assign en_right  = r_en_right;
  assign duty      = r_duty;
  assign state_dbg = r_state;

endmodule
